// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S processor: the instruction classes that data_path
// decodes and control_unit sequences.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNEG   = 4'd10,
    I_HALT   = 4'd11
  } decoded_instruction_type;

endpackage

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the K&S processor. Drives the
// data_path strobes and selects, and counts retired instructions (saturating).
module control_unit
  import k_and_s_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  input  logic                    ram_ready,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic [CNT_W-1:0]        instr_count
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_LOAD,
    S_EXEC_STORE,
    S_EXEC_ALU,
    S_EXEC_BR,
    S_HALT
  } state_t;

  state_t state;
  state_t next_state;
  logic   retire;
  logic   taken;

  // Overflow flags are exported by data_path but no branch condition uses them.
  logic unused_flags;
  assign unused_flags = unsigned_overflow ^ signed_overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (retire && (instr_count != '1))
        instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    taken = 1'b0;
    unique case (decoded_instruction)
      I_BRANCH: taken = 1'b1;
      I_BZERO:  taken = zero_op;
      I_BNEG:   taken = neg_op;
      default:  taken = 1'b0;
    endcase
  end

  // Strobes are forced low while rst is asserted so an interrupted access never writes.
  always_comb begin
    next_state       = state;
    retire           = 1'b0;
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = 2'b00;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = (state == S_HALT);

    if (!rst) begin
      case (state)
        S_FETCH: begin
          if (ram_ready) begin
            ir_enable  = 1'b1;
            pc_enable  = 1'b1;
            next_state = S_DECODE;
          end
        end

        S_DECODE: begin
          case (decoded_instruction)
            I_HALT: begin
              next_state = S_HALT;
              retire     = 1'b1;
            end
            I_LOAD:  next_state = S_EXEC_LOAD;
            I_STORE: next_state = S_EXEC_STORE;
            I_MOVE, I_ADD, I_SUB, I_AND, I_OR:
              next_state = S_EXEC_ALU;
            I_BRANCH, I_BZERO, I_BNEG:
              next_state = S_EXEC_BR;
            default: begin
              next_state = S_FETCH;
              retire     = 1'b1;
            end
          endcase
        end

        S_EXEC_LOAD: begin
          addr_sel = 1'b1;
          c_sel    = 1'b1;
          if (ram_ready) begin
            write_reg_enable = 1'b1;
            retire           = 1'b1;
            next_state       = S_FETCH;
          end
        end

        S_EXEC_STORE: begin
          addr_sel = 1'b1;
          if (ram_ready) begin
            ram_write_enable = 1'b1;
            retire           = 1'b1;
            next_state       = S_FETCH;
          end
        end

        S_EXEC_ALU: begin
          write_reg_enable = 1'b1;
          retire           = 1'b1;
          next_state       = S_FETCH;
          // MOVE is computed as a|a and leaves the flags untouched.
          case (decoded_instruction)
            I_ADD: begin
              operation        = 2'b00;
              flags_reg_enable = 1'b1;
            end
            I_SUB: begin
              operation        = 2'b01;
              flags_reg_enable = 1'b1;
            end
            I_AND: begin
              operation        = 2'b10;
              flags_reg_enable = 1'b1;
            end
            I_OR: begin
              operation        = 2'b11;
              flags_reg_enable = 1'b1;
            end
            I_MOVE:  operation = 2'b11;
            default: operation = 2'b00;
          endcase
        end

        S_EXEC_BR: begin
          branch     = taken;
          pc_enable  = taken;
          retire     = 1'b1;
          next_state = S_FETCH;
        end

        S_HALT: next_state = S_HALT;

        default: next_state = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench for control_unit: each instruction is expanded
// into its expected per-cycle output trace and compared cycle by cycle.
module tb_control_unit;
  import k_and_s_pkg::*;

  localparam int W    = 3;
  localparam int MAXC = (1 << W) - 1;

  localparam logic [10:0] BR = 11'h400;
  localparam logic [10:0] PC = 11'h200;
  localparam logic [10:0] IR = 11'h100;
  localparam logic [10:0] AS = 11'h080;
  localparam logic [10:0] CS = 11'h040;
  localparam logic [10:0] WR = 11'h008;
  localparam logic [10:0] FL = 11'h004;
  localparam logic [10:0] RW = 11'h002;
  localparam logic [10:0] HL = 11'h001;

  logic                    clk = 1'b0;
  logic                    rst;
  decoded_instruction_type decoded_instruction;
  logic                    zero_op;
  logic                    neg_op;
  logic                    unsigned_overflow;
  logic                    signed_overflow;
  logic                    ram_ready;
  logic                    branch;
  logic                    pc_enable;
  logic                    ir_enable;
  logic                    addr_sel;
  logic                    c_sel;
  logic [1:0]              operation;
  logic                    write_reg_enable;
  logic                    flags_reg_enable;
  logic                    ram_write_enable;
  logic                    halt;
  logic [W-1:0]            instr_count;

  int   total = 0;
  int   bad = 0;
  int   expCount = 0;
  logic halted = 1'b0;

  control_unit #(.CNT_W(W)) dut (
    .clk                (clk),
    .rst                (rst),
    .decoded_instruction(decoded_instruction),
    .zero_op            (zero_op),
    .neg_op             (neg_op),
    .unsigned_overflow  (unsigned_overflow),
    .signed_overflow    (signed_overflow),
    .ram_ready          (ram_ready),
    .branch             (branch),
    .pc_enable          (pc_enable),
    .ir_enable          (ir_enable),
    .addr_sel           (addr_sel),
    .c_sel              (c_sel),
    .operation          (operation),
    .write_reg_enable   (write_reg_enable),
    .flags_reg_enable   (flags_reg_enable),
    .ram_write_enable   (ram_write_enable),
    .halt               (halt),
    .instr_count        (instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] outVec();
    return {branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
            write_reg_enable, flags_reg_enable, ram_write_enable, halt};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic applyStimulus(input decoded_instruction_type ins, input logic rr,
                               input logic z, input logic n, input logic r);
    @(negedge clk);
    decoded_instruction = ins;
    ram_ready           = rr;
    zero_op             = z;
    neg_op              = n;
    unsigned_overflow   = 1'($urandom);
    signed_overflow     = 1'($urandom);
    rst                 = r;
    #1;
  endtask

  task automatic step(input string tag, input decoded_instruction_type ins, input logic rr,
                      input logic z, input logic n, input logic [10:0] exp);
    applyStimulus(ins, rr, z, n, 1'b0);
    checkOutput(tag, {21'd0, outVec()}, {21'd0, exp});
    checkOutput({tag, "_count"}, 32'(instr_count), 32'(expCount));
  endtask

  task automatic retire();
    if (expCount < MAXC) expCount++;
  endtask

  task automatic doReset(input int cycles, input decoded_instruction_type ins);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus(ins, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      checkOutput("reset_strobes", {21'd0, outVec() & ~HL}, 32'd0);
      if (i > 0) checkOutput("reset_count", 32'(instr_count), 32'd0);
    end
    expCount = 0;
    halted   = 1'b0;
  endtask

  function automatic logic [10:0] aluExpect(input decoded_instruction_type ins);
    logic [1:0] op;
    case (ins)
      I_ADD:   op = 2'b00;
      I_SUB:   op = 2'b01;
      I_AND:   op = 2'b10;
      default: op = 2'b11;
    endcase
    return WR | ((ins == I_MOVE) ? 11'd0 : FL) | {5'd0, op, 4'd0};
  endfunction

  task automatic runInstr(input decoded_instruction_type ins, input int fw, input int ew,
                          input logic z, input logic n);
    logic taken;
    for (int i = 0; i < fw; i++) step("fetch_wait", ins, 1'b0, z, n, 11'd0);
    step("fetch", ins, 1'b1, z, n, IR | PC);
    step("decode", ins, 1'($urandom), z, n, 11'd0);
    case (ins)
      I_LOAD: begin
        for (int i = 0; i < ew; i++) step("load_wait", ins, 1'b0, z, n, AS | CS);
        step("load", ins, 1'b1, z, n, AS | CS | WR);
      end
      I_STORE: begin
        for (int i = 0; i < ew; i++) step("store_wait", ins, 1'b0, z, n, AS);
        step("store", ins, 1'b1, z, n, AS | RW);
      end
      I_MOVE, I_ADD, I_SUB, I_AND, I_OR:
        step("alu", ins, 1'($urandom), z, n, aluExpect(ins));
      I_BRANCH, I_BZERO, I_BNEG: begin
        taken = (ins == I_BRANCH) || (ins == I_BZERO && z) || (ins == I_BNEG && n);
        step("branch", ins, 1'($urandom), z, n, taken ? (BR | PC) : 11'd0);
      end
      I_HALT: halted = 1'b1;
      default: ;
    endcase
    retire();
  endtask

  task automatic holdHalt(input int cycles);
    logic [3:0] raw;
    for (int i = 0; i < cycles; i++) begin
      raw = 4'($urandom_range(0, 15));
      step("halt", decoded_instruction_type'(raw), 1'($urandom), 1'($urandom), 1'($urandom), HL);
    end
  endtask

  initial begin
    logic [3:0] raw;
    int         n;
    rst                 = 1'b1;
    decoded_instruction = I_NOP;
    ram_ready           = 1'b0;
    zero_op             = 1'b0;
    neg_op              = 1'b0;
    unsigned_overflow   = 1'b0;
    signed_overflow     = 1'b0;

    doReset(2, I_NOP);

    runInstr(I_ADD, 0, 0, 1'b0, 1'b0);
    runInstr(I_LOAD, 1, 3, 1'b0, 1'b0);
    runInstr(I_BZERO, 0, 0, 1'b1, 1'b0);
    runInstr(I_BZERO, 0, 0, 1'b0, 1'b1);
    runInstr(I_BNEG, 0, 0, 1'b0, 1'b1);
    runInstr(I_MOVE, 0, 0, 1'b1, 1'b1);
    runInstr(I_STORE, 2, 2, 1'b0, 1'b0);
    runInstr(I_SUB, 0, 0, 1'b0, 1'b0);

    // Abort a LOAD that is waiting on RAM; the write must never appear.
    doReset(2, I_NOP);
    step("abort_fetch", I_LOAD, 1'b1, 1'b0, 1'b0, IR | PC);
    step("abort_decode", I_LOAD, 1'b1, 1'b0, 1'b0, 11'd0);
    step("abort_wait", I_LOAD, 1'b0, 1'b0, 1'b0, AS | CS);
    doReset(2, I_LOAD);
    step("post_reset_fetch", I_LOAD, 1'b0, 1'b0, 1'b0, 11'd0);
    runInstr(I_LOAD, 0, 0, 1'b0, 1'b0);
    runInstr(decoded_instruction_type'(4'd13), 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < MAXC + 2; i++) runInstr(I_NOP, 0, 0, 1'b0, 1'b0);
    runInstr(I_HALT, 0, 0, 1'b0, 1'b0);
    holdHalt(100);

    for (int b = 0; b < 25; b++) begin
      doReset(1 + $urandom_range(0, 1), I_NOP);
      n = $urandom_range(1, 20);
      for (int k = 0; k < n; k++) begin
        raw = 4'($urandom_range(0, 15));
        runInstr(decoded_instruction_type'(raw), $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom), 1'($urandom));
        if (halted) begin
          holdHalt($urandom_range(2, 8));
          break;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
